vme_slave_responder: RTL and testbench

- VME A24 slave/responder for the k30p card: lets a remote VME master read and write local RAM.
- It decodes the incoming cycle and takes the local 68030 bus via BR/BG/BGACK.
- It drives local RAM strobes and byte lanes, then answers with DTACK, or with BERR on an illegal cycle or a timeout.
- Sits beside the initiator-side VME logic; the top level turns its active-low outputs into open-drain drives on the bus.

---
 rtl/vme_slave_responder.sv | 202 ++++++++++++++++++++
 tb/tb_vme_slave_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_slave_responder.sv
// VME A24 slave responder: decodes a remote VME cycle, borrows the local 68030 bus
// through BR/BG/BGACK, strobes local RAM and answers with DTACK or BERR.
module vme_slave_responder #(
  parameter logic [3:0]  WINDOW         = 4'h2,
  parameter int unsigned ACCESS_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_lword,
  input  logic       vme_write,
  input  logic       vme_iack,
  input  logic [5:0] vme_address_mod,
  input  logic [3:0] vme_address_high,
  input  logic       vme_address_a1,
  output logic       vme_dtack_out,
  output logic       vme_berr_out,
  input  logic       cpu_as,
  output logic       cpu_bus_request,
  input  logic       cpu_bus_grant,
  output logic       cpu_bus_grant_ack,
  output logic       local_request,
  output logic [3:0] local_ds,
  output logic       local_write,
  output logic       slave_addr_oe,
  output logic       slave_data_oe,
  output logic       slave_data_dir,
  output logic       slave_busy
);

  localparam logic [7:0] AccessLast  = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StDecode, StIgnore, StReqBus, StAccess, StDtack, StBerr, StRelease
  } state_e;

  state_e state_q;
  logic [7:0] count_q;

  // Synchroniser bundle: {vme_as, vme_ds[1:0], cpu_as, cpu_bus_grant}, idle = all ones.
  logic [4:0] sync1_q, sync2_q;
  logic       as_s, cpu_as_s, bg_s;
  logic [1:0] ds_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {vme_as, vme_ds, cpu_as, cpu_bus_grant};
      sync2_q <= sync1_q;
    end
  end

  assign {as_s, ds_s, cpu_as_s, bg_s} = sync2_q;

  logic [5:0] am_q;
  logic [3:0] high_q;
  logic [1:0] ds_q;
  logic       a1_q, lword_q, write_q, iack_q;

  logic       selected, illegal, release_now;
  logic [3:0] lanes;

  always_comb begin
    selected = (am_q inside {6'h39, 6'h3A, 6'h3D, 6'h3E}) && (high_q == WINDOW);
    illegal  = !iack_q || (!lword_q && (a1_q || ds_q != 2'b00));
    lanes    = 4'b1111;
    if (!lword_q) begin
      lanes = 4'b0000;
    end else if (!a1_q) begin
      lanes[3] = ds_q[1];
      lanes[2] = ds_q[0];
    end else begin
      lanes[1] = ds_q[1];
      lanes[0] = ds_q[0];
    end
    // Master abort while holding the bus, or end of data phase after DTACK/BERR.
    release_now = ((state_q == StReqBus || state_q == StAccess) && as_s) ||
                  ((state_q == StDtack || state_q == StBerr) && ds_s == 2'b11);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      count_q           <= '0;
      am_q              <= '0;
      high_q            <= '0;
      ds_q              <= 2'b11;
      a1_q              <= 1'b0;
      lword_q           <= 1'b1;
      write_q           <= 1'b1;
      iack_q            <= 1'b1;
      vme_dtack_out     <= 1'b1;
      vme_berr_out      <= 1'b1;
      cpu_bus_request   <= 1'b1;
      cpu_bus_grant_ack <= 1'b1;
      local_request     <= 1'b1;
      local_ds          <= 4'b1111;
      local_write       <= 1'b1;
      slave_addr_oe     <= 1'b1;
      slave_data_oe     <= 1'b1;
      slave_data_dir    <= 1'b0;
      slave_busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!as_s && ds_s != 2'b11) begin
            am_q       <= vme_address_mod;
            high_q     <= vme_address_high;
            a1_q       <= vme_address_a1;
            lword_q    <= vme_lword;
            write_q    <= vme_write;
            iack_q     <= vme_iack;
            ds_q       <= ds_s;
            slave_busy <= 1'b1;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          if (!selected) begin
            state_q <= StIgnore;
          end else if (illegal) begin
            vme_berr_out <= 1'b0;
            state_q      <= StBerr;
          end else begin
            cpu_bus_request <= 1'b0;
            count_q         <= '0;
            state_q         <= StReqBus;
          end
        end
        StIgnore: begin
          if (as_s) begin
            slave_busy <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StReqBus: begin
          if (as_s) begin
            state_q <= StRelease;
          end else if (!bg_s && cpu_as_s) begin
            // Grant is checked before the timeout so a same-clock grant wins.
            cpu_bus_request   <= 1'b1;
            cpu_bus_grant_ack <= 1'b0;
            local_request     <= 1'b0;
            local_ds          <= lanes;
            local_write       <= write_q;
            slave_addr_oe     <= 1'b0;
            slave_data_oe     <= 1'b0;
            slave_data_dir    <= !write_q;
            count_q           <= '0;
            state_q           <= StAccess;
          end else if (count_q == TimeoutLast) begin
            cpu_bus_request <= 1'b1;
            vme_berr_out    <= 1'b0;
            state_q         <= StBerr;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        StAccess: begin
          if (as_s) begin
            state_q <= StRelease;
          end else if (count_q == AccessLast) begin
            vme_dtack_out <= 1'b0;
            state_q       <= StDtack;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        StDtack, StBerr: begin
          if (ds_s == 2'b11) state_q <= StRelease;
        end
        StRelease: begin
          if (as_s) begin
            slave_busy <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (release_now) begin
        vme_dtack_out     <= 1'b1;
        vme_berr_out      <= 1'b1;
        cpu_bus_request   <= 1'b1;
        cpu_bus_grant_ack <= 1'b1;
        local_request     <= 1'b1;
        local_ds          <= 4'b1111;
        local_write       <= 1'b1;
        slave_addr_oe     <= 1'b1;
        slave_data_oe     <= 1'b1;
        slave_data_dir    <= 1'b0;
        count_q           <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vme_slave_responder.sv
// Randomised scoreboard bench for vme_slave_responder against a byte-address reference model.
module tb_vme_slave_responder;

  localparam logic [3:0] Window  = 4'h2;
  localparam int         Access  = 4;
  localparam int         Timeout = 255;

  logic       clock = 1'b0;
  logic       reset;
  logic       vme_as, vme_lword, vme_write, vme_iack, vme_address_a1;
  logic [1:0] vme_ds;
  logic [5:0] vme_address_mod;
  logic [3:0] vme_address_high;
  logic       vme_dtack_out, vme_berr_out;
  logic       cpu_as, cpu_bus_request, cpu_bus_grant, cpu_bus_grant_ack;
  logic       local_request, local_write;
  logic [3:0] local_ds;
  logic       slave_addr_oe, slave_data_oe, slave_data_dir, slave_busy;

  always #5 clock = ~clock;

  vme_slave_responder #(
    .WINDOW(Window), .ACCESS_CYCLES(Access), .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock(clock), .reset(reset),
    .vme_as(vme_as), .vme_ds(vme_ds), .vme_lword(vme_lword), .vme_write(vme_write),
    .vme_iack(vme_iack), .vme_address_mod(vme_address_mod),
    .vme_address_high(vme_address_high), .vme_address_a1(vme_address_a1),
    .vme_dtack_out(vme_dtack_out), .vme_berr_out(vme_berr_out),
    .cpu_as(cpu_as), .cpu_bus_request(cpu_bus_request), .cpu_bus_grant(cpu_bus_grant),
    .cpu_bus_grant_ack(cpu_bus_grant_ack), .local_request(local_request),
    .local_ds(local_ds), .local_write(local_write), .slave_addr_oe(slave_addr_oe),
    .slave_data_oe(slave_data_oe), .slave_data_dir(slave_data_dir),
    .slave_busy(slave_busy)
  );

  typedef struct packed {
    logic       is_berr;
    logic       timeout;
    logic [3:0] lanes;
    logic       wr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Outputs packed: dtack berr br bgack req ds[3:0] write addr_oe data_oe dir busy
  function automatic logic [13:0] out_vec();
    return {vme_dtack_out, vme_berr_out, cpu_bus_request, cpu_bus_grant_ack, local_request,
            local_ds, local_write, slave_addr_oe, slave_data_oe, slave_data_dir, slave_busy};
  endfunction

  localparam logic [13:0] IdleVec = 14'b11111_1111_111_0_0;

  // Reference model: bytes addressed big-endian; DS1 = even byte, DS0 = odd byte.
  function automatic logic [3:0] model_lanes(input logic lword, input logic a1,
                                             input logic [1:0] ds);
    logic [3:0] en;
    en = 4'b1111;
    if (!lword) return 4'b0000;
    for (int off = 0; off < 2; off++)
      if (!ds[1-off]) en[3 - (2 * int'(a1) + off)] = 1'b0;
    return en;
  endfunction

  function automatic int model_kind(input logic [5:0] am, input logic [3:0] hi,
                                    input logic a1, input logic lword, input logic iack,
                                    input logic [1:0] ds);
    if (!(am inside {6'h39, 6'h3A, 6'h3D, 6'h3E}) || hi != Window) return 0;
    if (!iack) return 2;
    if (!lword && (a1 || ds != 2'b00)) return 2;
    return 1;
  endfunction

  // gdelay < 0: bus never granted.
  task automatic run_cycle(input logic [5:0] am, input logic [3:0] hi, input logic a1,
                           input logic lword, input logic wr, input logic iack,
                           input logic [1:0] ds, input int gdelay);
    int   kind, brcnt;
    logic seen, done;
    exp_t e;
    kind = model_kind(am, hi, a1, lword, iack, ds);
    e.is_berr = (kind == 2) || (kind == 1 && gdelay < 0);
    e.timeout = (kind == 1 && gdelay < 0);
    e.lanes   = model_lanes(lword, a1, ds);
    e.wr      = wr;
    if (kind != 0) sb_q.push_back(e);
    @(posedge clock); #1;
    vme_address_mod = am; vme_address_high = hi; vme_address_a1 = a1;
    vme_lword = lword; vme_write = wr; vme_iack = iack;
    vme_as = 1'b0; vme_ds = ds;
    if (kind == 0) begin
      seen = 1'b0;
      repeat (12) begin
        @(posedge clock); #1;
        if (!cpu_bus_request || !vme_dtack_out || !vme_berr_out) seen = 1'b1;
      end
      check("ignore_quiet", seen, 0);
      check("ignore_busy", slave_busy, 1);
    end else begin
      done = 1'b0; brcnt = 0;
      for (int i = 0; i < 400 && !done; i++) begin
        @(posedge clock); #1;
        if (!cpu_bus_request) brcnt++;
        if (gdelay >= 0 && brcnt > gdelay) cpu_bus_grant = 1'b0;
        if (!vme_dtack_out || !vme_berr_out) done = 1'b1;
      end
      check("cycle_terminated", done, 1);
    end
    vme_ds = 2'b11; vme_as = 1'b1; cpu_bus_grant = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("released_idle", out_vec(), IdleVec);
  endtask

  // Monitor: pops an expectation whenever DTACK or BERR falls.
  logic prev_dtack, prev_berr, prev_br, br_fell;
  int   acc_run, br_run;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      prev_dtack = 1'b1; prev_berr = 1'b1; prev_br = 1'b1; br_fell = 1'b0;
      acc_run = 0; br_run = 0;
    end else begin
      if (!cpu_bus_request && prev_br) begin br_fell = 1'b1; br_run = 0; end
      if (!cpu_bus_request) br_run++;
      if (local_request) acc_run = 0;
      else if (vme_dtack_out) acc_run++;
      if (!vme_dtack_out && prev_dtack) begin
        if (sb_q.size() == 0) check("dtack_expected", 0, 1);
        else begin
          e = sb_q.pop_front();
          check("dtack_kind", e.is_berr, 0);
          check("dtack_lanes", local_ds, e.lanes);
          check("dtack_write", local_write, e.wr);
          check("dtack_dir", slave_data_dir, !e.wr);
          check("dtack_bufs", {slave_addr_oe, slave_data_oe, local_request}, 0);
          check("dtack_bus", {cpu_bus_grant_ack, cpu_bus_request}, 2'b01);
          check("access_clocks", acc_run, Access);
        end
        br_fell = 1'b0;
      end
      if (!vme_berr_out && prev_berr) begin
        if (sb_q.size() == 0) check("berr_expected", 0, 1);
        else begin
          e = sb_q.pop_front();
          check("berr_kind", e.is_berr, 1);
          check("berr_no_dtack", vme_dtack_out, 1);
          check("berr_br_released", cpu_bus_request, 1);
          check("berr_br_seen", br_fell, e.timeout);
          if (e.timeout) check("timeout_clocks", br_run, Timeout);
        end
        br_fell = 1'b0;
      end
      prev_dtack = vme_dtack_out; prev_berr = vme_berr_out; prev_br = cpu_bus_request;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] am;
    logic [3:0] hi;
    logic [1:0] ds;
    logic       got;
    reset = 1'b0;
    vme_as = 1'b1; vme_ds = 2'b11; vme_lword = 1'b1; vme_write = 1'b1; vme_iack = 1'b1;
    vme_address_mod = '0; vme_address_high = '0; vme_address_a1 = 1'b0;
    cpu_as = 1'b1; cpu_bus_grant = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", out_vec(), IdleVec);
    reset = 1'b1;

    run_cycle(6'h39, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3);  // longword write
    run_cycle(6'h39, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1);  // byte read, DS0 only
    run_cycle(6'h3E, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 0);  // word write, low half
    run_cycle(6'h39, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 0);  // outside window
    run_cycle(6'h09, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 0);  // foreign AM
    run_cycle(6'h3A, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 0);  // LWORD with A1
    run_cycle(6'h3D, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 0);  // IACK cycle
    run_cycle(6'h39, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, -1); // grant timeout

    // Reset during ACCESS: outputs must drop without waiting for a clock.
    @(posedge clock); #1;
    vme_address_mod = 6'h39; vme_address_high = 4'h2; vme_address_a1 = 1'b0;
    vme_lword = 1'b0; vme_write = 1'b0; vme_iack = 1'b1;
    vme_as = 1'b0; vme_ds = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clock); #1;
      if (!cpu_bus_request) cpu_bus_grant = 1'b0;
      if (!local_request) got = 1'b1;
    end
    check("reached_access", got, 1);
    #1 reset = 1'b0;
    #1 check("async_reset_release", out_vec(), IdleVec);
    vme_as = 1'b1; vme_ds = 2'b11; cpu_bus_grant = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    run_cycle(6'h39, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: am = 6'h39;
        1: am = 6'h3A;
        2: am = 6'h3D;
        3: am = 6'h3E;
        4: am = 6'h09;
        default: am = 6'($urandom);
      endcase
      hi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : Window;
      case ($urandom_range(0, 2))
        0: ds = 2'b00;
        1: ds = 2'b01;
        default: ds = 2'b10;
      endcase
      run_cycle(am, hi, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 7) != 0, ds, int'($urandom_range(0, 5)));
    end

    repeat (4) @(posedge clock);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
